// File: rtl/id_ex_pipe_reg.sv
// Decode-to-execute pipeline register with stall (hold), flush (bubble) and valid tracking.
// Optional bubble counter on BubbleCntE is enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallE,
  input  logic            FlushE,
  input  logic            ValidD,
  input  logic            RegWriteD,
  input  logic            MemWriteD,
  input  logic            BranchD,
  input  logic            JumpD,
  input  logic            ALUSrcAD,
  input  logic [1:0]      ResultSrcD,
  input  logic [1:0]      ALUSrcBD,
  input  logic [2:0]      ALUControlD,
  input  logic [2:0]      funct3D,
  input  logic [XLEN-1:0] RD1D,
  input  logic [XLEN-1:0] RD2D,
  input  logic [XLEN-1:0] ImmExtD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic [4:0]      Rs1D,
  input  logic [4:0]      Rs2D,
  input  logic [4:0]      RdD,
  output logic            ValidE,
  output logic            RegWriteE,
  output logic            MemWriteE,
  output logic            BranchE,
  output logic            JumpE,
  output logic            ALUSrcAE,
  output logic [1:0]      ResultSrcE,
  output logic [1:0]      ALUSrcBE,
  output logic [2:0]      ALUControlE,
  output logic [2:0]      funct3E,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [4:0]      RdE,
  output logic [15:0]     BubbleCntE
);

  typedef struct packed {
    logic            valid;
    logic            reg_write;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic            alu_src_a;
    logic [1:0]      result_src;
    logic [1:0]      alu_src_b;
    logic [2:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } slot_t;

  slot_t slot_d_s;
  slot_t slot_nxt_s;
  slot_t slot_r;

  // Gather decode-stage fields into one slot image
  always_comb begin
    slot_d_s             = '0;
    slot_d_s.valid       = ValidD;
    slot_d_s.reg_write   = RegWriteD;
    slot_d_s.mem_write   = MemWriteD;
    slot_d_s.branch      = BranchD;
    slot_d_s.jump        = JumpD;
    slot_d_s.alu_src_a   = ALUSrcAD;
    slot_d_s.result_src  = ResultSrcD;
    slot_d_s.alu_src_b   = ALUSrcBD;
    slot_d_s.alu_control = ALUControlD;
    slot_d_s.funct3      = funct3D;
    slot_d_s.rd1         = RD1D;
    slot_d_s.rd2         = RD2D;
    slot_d_s.imm_ext     = ImmExtD;
    slot_d_s.pc          = PCD;
    slot_d_s.pc_plus4    = PCPlus4D;
    slot_d_s.rs1         = Rs1D;
    slot_d_s.rs2         = Rs2D;
    slot_d_s.rd          = RdD;
  end

  // Next slot: flush beats stall, stall beats load
  always_comb begin
    slot_nxt_s = slot_r;
    if (FlushE) begin
      slot_nxt_s = '0;
    end else if (StallE) begin
      slot_nxt_s = slot_r;
    end else begin
      slot_nxt_s = slot_d_s;
    end
  end

  // Slot register; all-zero reset is a bubble so control outputs never carry X
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= '0;
    end else begin
      slot_r <= slot_nxt_s;
    end
  end

  assign ValidE      = slot_r.valid;
  assign RegWriteE   = slot_r.reg_write;
  assign MemWriteE   = slot_r.mem_write;
  assign BranchE     = slot_r.branch;
  assign JumpE       = slot_r.jump;
  assign ALUSrcAE    = slot_r.alu_src_a;
  assign ResultSrcE  = slot_r.result_src;
  assign ALUSrcBE    = slot_r.alu_src_b;
  assign ALUControlE = slot_r.alu_control;
  assign funct3E     = slot_r.funct3;
  assign RD1E        = slot_r.rd1;
  assign RD2E        = slot_r.rd2;
  assign ImmExtE     = slot_r.imm_ext;
  assign PCE         = slot_r.pc;
  assign PCPlus4E    = slot_r.pc_plus4;
  assign Rs1E        = slot_r.rs1;
  assign Rs2E        = slot_r.rs2;
  assign RdE         = slot_r.rd;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic        bubble_evt_s;
  logic [15:0] bubble_cnt_r;

  // A bubble enters execute on a flush or on an unstalled invalid decode slot
  always_comb begin
    bubble_evt_s = FlushE | (~StallE & ~ValidD);
  end

  // Saturating bubble counter, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_r <= 16'h0000;
    end else if (bubble_evt_s && (bubble_cnt_r != 16'hFFFF)) begin
      bubble_cnt_r <= bubble_cnt_r + 16'd1;
    end else begin
      bubble_cnt_r <= bubble_cnt_r;
    end
  end

  assign BubbleCntE = bubble_cnt_r;
`else
  assign BubbleCntE = 16'h0000;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed self-checking bench for id_ex_pipe_reg; expected bubble counts depend on ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_pipe_reg;

  logic        clk;
  logic        rst_n;
  logic        StallE, FlushE, ValidD;
  logic        RegWriteD, MemWriteD, BranchD, JumpD, ALUSrcAD;
  logic [1:0]  ResultSrcD, ALUSrcBD;
  logic [2:0]  ALUControlD, funct3D;
  logic [31:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        ValidE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcAE;
  logic [1:0]  ResultSrcE, ALUSrcBE;
  logic [2:0]  ALUControlE, funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic [15:0] BubbleCntE;

  int          n_chk;
  int          n_fail;
  logic [15:0] exp_cnt;

  id_ex_pipe_reg #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD), .JumpD(JumpD),
    .ALUSrcAD(ALUSrcAD), .ResultSrcD(ResultSrcD), .ALUSrcBD(ALUSrcBD),
    .ALUControlD(ALUControlD), .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D),
    .ImmExtD(ImmExtD), .PCD(PCD), .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RdD(RdD), .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE),
    .BranchE(BranchE), .JumpE(JumpE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
    .ALUSrcBE(ALUSrcBE), .ALUControlE(ALUControlE), .funct3E(funct3E), .RD1E(RD1E),
    .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E),
    .Rs2E(Rs2E), .RdE(RdE), .BubbleCntE(BubbleCntE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge; inputs are sampled before it, outputs checked 1 time unit after it
  task automatic step();
    logic evt;
    evt = FlushE | (~StallE & ~ValidD);
    @(posedge clk);
    #1;
`ifdef ID_EX_BUBBLE_CNT_EN
    if (evt && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
`else
    evt = 1'b0;
`endif
  endtask

  task automatic drive_all_nonzero();
    ValidD = 1'b1; RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1; JumpD = 1'b1;
    ALUSrcAD = 1'b1; ResultSrcD = 2'b11; ALUSrcBD = 2'b10; ALUControlD = 3'b111;
    funct3D = 3'b101; RD1D = 32'hDEAD_BEEF; RD2D = 32'hCAFE_F00D; ImmExtD = 32'hFFFF_FFF0;
    PCD = 32'h0000_1000; PCPlus4D = 32'h0000_1004; Rs1D = 5'd31; Rs2D = 5'd30; RdD = 5'd29;
  endtask

  initial begin
    n_chk = 0; n_fail = 0; exp_cnt = 16'h0000;
    rst_n = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    drive_all_nonzero();

    // Reset state with nonzero D inputs and a running clock
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_regwrite", RegWriteE, 1'b0);
    check_eq("rst_valid", ValidE, 1'b0);
    check_eq("rst_rd1", RD1E, 32'h0);
    check_eq("rst_pc", PCE, 32'h0);
    check_eq("rst_rd", RdE, 5'd0);
    check_eq("rst_cnt", BubbleCntE, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through
    RegWriteD = 1'b1; MemWriteD = 1'b0; BranchD = 1'b0; JumpD = 1'b0;
    ALUControlD = 3'b010; RD1D = 32'h0000_1234; RdD = 5'd7; ValidD = 1'b1;
    step();
    check_eq("pt_regwrite", RegWriteE, 1'b1);
    check_eq("pt_aluctl", ALUControlE, 3'b010);
    check_eq("pt_rd1", RD1E, 32'h0000_1234);
    check_eq("pt_rd", RdE, 5'd7);
    check_eq("pt_valid", ValidE, 1'b1);
    check_eq("pt_rd2", RD2E, 32'hCAFE_F00D);
    check_eq("pt_imm", ImmExtE, 32'hFFFF_FFF0);
    check_eq("pt_pc4", PCPlus4E, 32'h0000_1004);
    check_eq("pt_rs1", Rs1E, 5'd31);
    check_eq("pt_srcb", ALUSrcBE, 2'b10);
    check_eq("pt_cnt", BubbleCntE, 16'h0);

    // Stall holds slot A for three edges
    RdD = 5'd5;
    step();
    check_eq("st_load", RdE, 5'd5);
    StallE = 1'b1; RdD = 5'd9; RD1D = 32'h0000_5555;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("st_hold_rd", RdE, 5'd5);
      check_eq("st_hold_rd1", RD1E, 32'h0000_1234);
    end
    StallE = 1'b0;
    step();
    check_eq("st_release_rd", RdE, 5'd9);
    check_eq("st_release_rd1", RD1E, 32'h0000_5555);

    // Flush together with stall inserts a bubble, then stall holds it
    MemWriteD = 1'b1;
    step();
    check_eq("fl_pre_memwrite", MemWriteE, 1'b1);
    FlushE = 1'b1; StallE = 1'b1;
    step();
    check_eq("fl_memwrite", MemWriteE, 1'b0);
    check_eq("fl_valid", ValidE, 1'b0);
    check_eq("fl_rd", RdE, 5'd0);
    check_eq("fl_rd2", RD2E, 32'h0);
    check_eq("fl_regwrite", RegWriteE, 1'b0);
    check_eq("fl_cnt", BubbleCntE, exp_cnt);
    FlushE = 1'b0;
    step();
    check_eq("fl_hold_rd", RdE, 5'd0);
    check_eq("fl_hold_memwrite", MemWriteE, 1'b0);
    check_eq("fl_hold_cnt", BubbleCntE, exp_cnt);

    // Invalid decode slots load normally but arrive invalid
    StallE = 1'b0; ValidD = 1'b0; RdD = 5'd3; MemWriteD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("inv_valid", ValidE, 1'b0);
      check_eq("inv_rd", RdE, 5'd3);
      check_eq("inv_regwrite", RegWriteE, 1'b1);
      check_eq("inv_cnt", BubbleCntE, exp_cnt);
    end

    // Asynchronous reset mid-stall
    ValidD = 1'b1; RdD = 5'd12;
    step();
    check_eq("ar_load", RdE, 5'd12);
    StallE = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 16'h0000;
    check_eq("ar_rd", RdE, 5'd0);
    check_eq("ar_valid", ValidE, 1'b0);
    check_eq("ar_regwrite", RegWriteE, 1'b0);
    check_eq("ar_cnt", BubbleCntE, 16'h0);
    #1;
    rst_n = 1'b1;
    step();
    check_eq("ar_stall_hold", RdE, 5'd0);
    StallE = 1'b0;
    step();
    check_eq("ar_resume", RdE, 5'd12);
    check_eq("ar_resume_cnt", BubbleCntE, 16'h0);

    // Long flush run: counter saturates with the macro, stays zero without it
    FlushE = 1'b1;
`ifdef ID_EX_BUBBLE_CNT_EN
    for (int i = 0; i < 65540; i++) step();
    check_eq("sat_cnt", BubbleCntE, 16'hFFFF);
    step();
    check_eq("sat_hold_cnt", BubbleCntE, 16'hFFFF);
`else
    for (int i = 0; i < 20; i++) step();
    check_eq("nocnt", BubbleCntE, 16'h0000);
`endif
    check_eq("sat_exp", BubbleCntE, exp_cnt);
    check_eq("sat_valid", ValidE, 1'b0);
    check_eq("sat_rd", RdE, 5'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
